btn_sw_input: RTL and testbench
===============================

BTN_SW_INPUT -- requirements
Module: btn_sw_input

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 50000: number of consecutive synchronized cycles a button must hold a new level before it is accepted; legal range 1..2^20.
REQ-002 SHALL have parameter BTN_ACTIVE_LOW, default 1: when 1, raw button pins are inverted so that a press reads as 1 internally.
REQ-003 SHALL have port clk, input, 1 bit: single clock for all state.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port sw_raw, input, 32 bits: asynchronous slide-switch pins.
REQ-006 SHALL have port btn_raw, input, 4 bits: asynchronous push-button pins.
REQ-007 SHALL have port btn_clr, input, 4 bits: per-button write-1-to-clear strobe from the LSU, one cycle wide.
REQ-008 SHALL have port io_sw, output, 32 bits: synchronized switch value presented to the LSU.
REQ-009 SHALL have port io_btn, output, 4 bits: debounced button level, 1 = pressed.
REQ-010 SHALL have port btn_evt, output, 4 bits: sticky per-button press flags.
REQ-011 SHALL have port btn_irq, output, 1 bit: OR of all btn_evt bits.

Function
REQ-012 SHALL pass each sw_raw bit through a 2-flop synchronizer; io_sw reflects a raw change after exactly 2 rising edges, with no debounce.
REQ-013 SHALL pass each btn_raw bit, after optional inversion, through a 2-flop synchronizer to produce btn_s.
REQ-014 SHALL give each button an independent debounce counter of width $clog2(DB_CYCLES+1) and a stable state register that drives io_btn.
REQ-015 SHALL, per button, behave as follows each cycle:
- If btn_s equals stable: counter is forced to 0.
- If btn_s differs from stable and counter is below DB_CYCLES-1: counter increments.
- If btn_s differs from stable and counter equals DB_CYCLES-1: stable takes btn_s and counter returns to 0.
REQ-016 SHALL therefore change io_btn exactly DB_CYCLES+2 rising edges after a clean raw transition.
REQ-017 SHALL restart the count from 0 on any glitch shorter than DB_CYCLES synchronized cycles, leaving io_btn unchanged.
REQ-018 SHALL, with DB_CYCLES=1, accept a new level on the first synchronized cycle in which it differs from stable.
REQ-019 SHALL set btn_evt[i] on the same edge that io_btn[i] goes 0->1; a 1->0 (release) transition SHALL NOT affect btn_evt.
REQ-020 SHALL clear btn_evt[i] on the edge after btn_clr[i]=1 is sampled.
REQ-021 SHALL give set priority when a set and btn_clr[i] occur in the same cycle: btn_evt[i] ends at 1.
REQ-022 SHALL have btn_clr[i]=1 while btn_evt[i]=0 do nothing, and SHALL have btn_clr bits operate independently per button.
REQ-023 SHALL keep the counter saturation-free: it never exceeds DB_CYCLES-1 and never wraps.
REQ-024 SHALL drive btn_irq as a combinational OR of the btn_evt bits, with no added latency.

Reset
REQ-025 SHALL, while rst_n=0, immediately force all of the following to 0, regardless of clk: synchronizer flops, counters, stable states, io_sw, io_btn, btn_evt, btn_irq.
REQ-026 SHALL, when rst_n is asserted mid-debounce, discard the in-progress count; after release, a held button needs a full DB_CYCLES+2 edges before io_btn=1, and that transition sets btn_evt.
REQ-027 SHALL resume synchronous operation on the first rising edge after rst_n deasserts.

Verification (DB_CYCLES=4, BTN_ACTIVE_LOW=1)
REQ-028 SHALL cover switch latency: reset, then sw_raw=32'h0000_0002 -> io_sw=2 after exactly 2 edges; io_btn stays 0.
REQ-029 SHALL cover a clean press: btn_raw[0] 1->0 held -> io_btn[0]=1 and btn_evt[0]=1 on edge 6, btn_irq=1 on the same edge; release -> io_btn[0]=0 on edge 6 after release, and btn_evt[0] stays 1.
REQ-030 SHALL cover bounce: btn_raw[1] toggled low 3 cycles, high 1 cycle, low and held -> no io_btn[1] change until 6 edges after the final low.
REQ-031 SHALL cover clearing: btn_clr=4'b0001 for one cycle with btn_evt=4'b0001 -> btn_evt=0 and btn_irq=0 on the next edge; btn_clr asserted on the press-accept edge -> btn_evt[0]=1.
REQ-032 SHALL cover reset mid-debounce: rst_n=0 at edge 3 of a press, released 2 cycles later with the button still held -> io_btn=0 asynchronously during reset, then io_btn=1 exactly 6 edges after rst_n rises.
REQ-033 SHALL cover independence: buttons 2 and 3 pressed 1 cycle apart -> btn_evt[2] and btn_evt[3] set 1 cycle apart; btn_clr=4'b0100 clears only bit 2.

Source files
------------

// File: rtl/btn_sw_input.sv
// Board input front end: synchronizes 32 slide switches and 4 push buttons.
// Buttons are debounced and latch sticky press events that raise an interrupt.
module btn_sw_input #(
    parameter int DB_CYCLES      = 50000,
    parameter int BTN_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] sw_raw,
    input  logic [3:0]  btn_raw,
    input  logic [3:0]  btn_clr,
    output logic [31:0] io_sw,
    output logic [3:0]  io_btn,
    output logic [3:0]  btn_evt,
    output logic        btn_irq
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [31:0]   sw_meta;
    logic [3:0]    btn_in;
    logic [3:0]    btn_meta;
    logic [3:0]    btn_s;
    logic [3:0]    stable;
    logic [3:0]    stable_nxt;
    logic [3:0]    rise;
    logic [3:0]    evt_nxt;
    logic [CW-1:0] cnt     [4];
    logic [CW-1:0] cnt_nxt [4];

    // Invert active-low pins so that a press is always 1 past this point.
    assign btn_in = (BTN_ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

    // A button must disagree with its stable level for DB_CYCLES consecutive
    // synchronized cycles; any agreeing cycle restarts the count from zero.
    always_comb begin
        stable_nxt = stable;
        for (int i = 0; i < 4; i++) begin
            cnt_nxt[i] = '0;
            if (btn_s[i] != stable[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    stable_nxt[i] = btn_s[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // A new press wins over a simultaneous clear so no event is ever lost.
    assign rise    = stable_nxt & ~stable;
    assign evt_nxt = (btn_evt & ~btn_clr) | rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta  <= '0;
            io_sw    <= '0;
            btn_meta <= '0;
            btn_s    <= '0;
            stable   <= '0;
            btn_evt  <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sw_meta  <= sw_raw;
            io_sw    <= sw_meta;
            btn_meta <= btn_in;
            btn_s    <= btn_meta;
            stable   <= stable_nxt;
            btn_evt  <= evt_nxt;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    assign io_btn  = stable;
    assign btn_irq = |btn_evt;

endmodule

// File: tb/tb_btn_sw_input.sv
// Self-checking bench for btn_sw_input with DB_CYCLES=4 and active-low buttons:
// directed scenarios followed by random traffic, all checked against a history-based model.
module tb_btn_sw_input;

    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] sw_raw;
    logic [3:0]  btn_raw;
    logic [3:0]  btn_clr;
    logic [31:0] io_sw;
    logic [3:0]  io_btn;
    logic [3:0]  btn_evt;
    logic        btn_irq;

    int checks = 0;
    int errors = 0;

    // Reference model: raw input history since reset, synchronized-sample history,
    // and the resulting expected outputs.
    bit [31:0] sw_q [$];
    bit [3:0]  raw_q [$];
    bit [3:0]  s_q [$];
    bit [31:0] m_sw;
    bit [3:0]  m_btn;
    bit [3:0]  m_evt;

    btn_sw_input #(
        .DB_CYCLES      (DB),
        .BTN_ACTIVE_LOW (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw_raw  (sw_raw),
        .btn_raw (btn_raw),
        .btn_clr (btn_clr),
        .io_sw   (io_sw),
        .io_btn  (io_btn),
        .btn_evt (btn_evt),
        .btn_irq (btn_irq)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        sw_q.delete();
        raw_q.delete();
        s_q.delete();
        m_sw  = '0;
        m_btn = '0;
        m_evt = '0;
    endfunction

    // Outputs after edge k: switches show the raw value seen at edge k-1; the debouncer
    // at edge k looks at the pressed state seen at edge k-2, and a button flips once its
    // last DB such samples all disagree with the accepted level.
    function automatic void model_edge();
        bit [3:0] s;
        bit [3:0] new_btn;
        bit [3:0] sample;
        bit       all_differ;
        sw_q.push_back(sw_raw);
        raw_q.push_back(~btn_raw);
        s = (raw_q.size() >= 3) ? raw_q[raw_q.size() - 3] : 4'b0000;
        s_q.push_back(s);
        new_btn = m_btn;
        if (s_q.size() >= DB) begin
            for (int b = 0; b < 4; b++) begin
                all_differ = 1'b1;
                for (int j = 1; j <= DB; j++) begin
                    sample = s_q[s_q.size() - j];
                    if (sample[b] == m_btn[b]) all_differ = 1'b0;
                end
                if (all_differ) new_btn[b] = ~m_btn[b];
            end
        end
        m_evt = (m_evt & ~btn_clr) | (new_btn & ~m_btn);
        m_btn = new_btn;
        m_sw  = (sw_q.size() >= 2) ? sw_q[sw_q.size() - 2] : 32'h0;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".io_sw"},   io_sw,            m_sw);
        checkVal({tag, ".io_btn"},  32'(io_btn),      32'(m_btn));
        checkVal({tag, ".btn_evt"}, 32'(btn_evt),     32'(m_evt));
        checkVal({tag, ".btn_irq"}, 32'(btn_irq),     32'(|m_evt));
    endtask

    task automatic applyStimulus(input logic [31:0] sw, input logic [3:0] btn, input logic [3:0] clr);
        sw_raw  = sw;
        btn_raw = btn;
        btn_clr = clr;
    endtask

    task automatic tick(input int n, input string tag);
        repeat (n) begin
            @(posedge clk);
            if (rst_n) model_edge();
            @(negedge clk);
            checkOutput(tag);
        end
    endtask

    // Drop reset between edges and check that everything clears without a clock.
    task automatic asyncReset(input string tag);
        rst_n = 1'b0;
        model_reset();
        #1;
        checkVal({tag, ".rst_io_sw"},   io_sw,        32'h0);
        checkVal({tag, ".rst_io_btn"},  32'(io_btn),  32'h0);
        checkVal({tag, ".rst_btn_evt"}, 32'(btn_evt), 32'h0);
        checkVal({tag, ".rst_btn_irq"}, 32'(btn_irq), 32'h0);
    endtask

    initial begin
        applyStimulus(32'h0, 4'hF, 4'h0);
        model_reset();
        asyncReset("por");
        tick(2, "in_reset");
        rst_n = 1'b1;

        // switch latency
        applyStimulus(32'h0000_0002, 4'hF, 4'h0);
        tick(1, "sw1");
        checkVal("sw_edge1", io_sw, 32'h0);
        tick(1, "sw2");
        checkVal("sw_edge2", io_sw, 32'h2);
        checkVal("sw_btn_idle", 32'(io_btn), 32'h0);

        // clean press and release of button 0
        applyStimulus(32'h2, 4'hE, 4'h0);
        tick(5, "press");
        checkVal("press_e5", 32'(io_btn), 32'h0);
        tick(1, "press");
        checkVal("press_e6_btn", 32'(io_btn),  32'h1);
        checkVal("press_e6_evt", 32'(btn_evt), 32'h1);
        checkVal("press_e6_irq", 32'(btn_irq), 32'h1);
        applyStimulus(32'h2, 4'hF, 4'h0);
        tick(5, "release");
        checkVal("release_e5", 32'(io_btn), 32'h1);
        tick(1, "release");
        checkVal("release_e6_btn", 32'(io_btn),  32'h0);
        checkVal("release_e6_evt", 32'(btn_evt), 32'h1);

        // write-1-to-clear, then clear colliding with a press
        applyStimulus(32'h2, 4'hF, 4'h1);
        tick(1, "clr");
        applyStimulus(32'h2, 4'hF, 4'h0);
        checkVal("clr_evt", 32'(btn_evt), 32'h0);
        checkVal("clr_irq", 32'(btn_irq), 32'h0);
        applyStimulus(32'h2, 4'hE, 4'h0);
        tick(5, "clr_press");
        applyStimulus(32'h2, 4'hE, 4'h1);
        tick(1, "clr_collide");
        applyStimulus(32'h2, 4'hE, 4'h0);
        checkVal("clr_collide_evt", 32'(btn_evt), 32'h1);
        applyStimulus(32'h2, 4'hF, 4'h0);
        tick(6, "clr_rel");
        applyStimulus(32'h2, 4'hF, 4'h1);
        tick(1, "clr2");
        applyStimulus(32'h2, 4'hF, 4'h0);

        // bounce on button 1
        applyStimulus(32'h2, 4'hD, 4'h0);
        tick(3, "bounce_lo");
        applyStimulus(32'h2, 4'hF, 4'h0);
        tick(1, "bounce_hi");
        applyStimulus(32'h2, 4'hD, 4'h0);
        tick(5, "bounce_hold");
        checkVal("bounce_e5", 32'(io_btn), 32'h0);
        tick(1, "bounce_hold");
        checkVal("bounce_e6", 32'(io_btn), 32'h2);
        applyStimulus(32'h2, 4'hF, 4'h0);
        tick(6, "bounce_rel");
        applyStimulus(32'h2, 4'hF, 4'h2);
        tick(1, "bounce_clr");
        applyStimulus(32'h2, 4'hF, 4'h0);

        // reset in the middle of a debounce with the button held throughout
        applyStimulus(32'h2, 4'hE, 4'h0);
        tick(3, "mid_press");
        asyncReset("mid");
        tick(2, "mid_in_reset");
        rst_n = 1'b1;
        tick(5, "mid_after");
        checkVal("mid_e5", 32'(io_btn), 32'h0);
        tick(1, "mid_after");
        checkVal("mid_e6_btn", 32'(io_btn),  32'h1);
        checkVal("mid_e6_evt", 32'(btn_evt), 32'h1);
        asyncReset("held");
        tick(1, "held_in_reset");
        rst_n = 1'b1;
        applyStimulus(32'h2, 4'hF, 4'h0);
        tick(8, "held_rel");
        applyStimulus(32'h2, 4'hF, 4'hF);
        tick(1, "held_clr");
        applyStimulus(32'h2, 4'hF, 4'h0);

        // buttons 2 and 3 pressed one cycle apart
        applyStimulus(32'h2, 4'hB, 4'h0);
        tick(1, "ind");
        applyStimulus(32'h2, 4'h3, 4'h0);
        tick(4, "ind");
        checkVal("ind_e5", 32'(btn_evt), 32'h0);
        tick(1, "ind");
        checkVal("ind_e6", 32'(btn_evt), 32'h4);
        tick(1, "ind");
        checkVal("ind_e7", 32'(btn_evt), 32'hC);
        applyStimulus(32'h2, 4'h3, 4'h4);
        tick(1, "ind_clr");
        applyStimulus(32'h2, 4'h3, 4'h0);
        checkVal("ind_clr_evt", 32'(btn_evt), 32'h8);

        // random traffic: hold each button pattern for a random stretch
        for (int seg = 0; seg < 120; seg++) begin
            logic [3:0]  rb;
            logic [31:0] rs;
            int          hold;
            rb   = 4'($urandom);
            rs   = $urandom;
            hold = $urandom_range(1, 8);
            for (int c = 0; c < hold; c++) begin
                applyStimulus(rs, rb, ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0);
                tick(1, "rand");
            end
            if (seg == 60) begin
                asyncReset("rand");
                tick(1, "rand_in_reset");
                rst_n = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
